// File: rtl/ascon_axis_word_packer.sv
// ascon_axis_word_packer
//   Input stage of the Ascon accelerator. Packs pairs of 32-bit AXI4-Stream
//   beats into 64-bit little-endian words (beat 0 -> [31:0], beat 1 ->
//   [63:32]). The last word of each packet carries its valid-byte count.
//
//   Optional feature, macro ASCON_PACKER_PAD_EN: byte padding (0x01 after the
//   last data byte) for AD/PT/CT/MSG/Z packets. A full last word is followed
//   by an extra pad word 64'h1.
//
//   TUSER encoding: KEY=1 NONCE=2 AD=3 PT=4 CT=5 TAG=6 MSG=7 Z=8.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   s_axis_tdata/tkeep  input bytes and byte enables (first byte in [7:0])
//   s_axis_tuser        packet data type, constant within a packet
//   s_axis_tlast        last beat of packet
//   s_axis_tvalid/ready beat handshake
//   w_data/type/bytes   packed word, its type and valid-byte count (0..8)
//   w_last              final word of packet
//   w_valid/w_ready     word handshake toward the core
//   err_tuser           sticky, TUSER changed inside a word
module ascon_axis_word_packer #(
  parameter int IN_WIDTH   = 32,
  parameter int WORD_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IN_WIDTH-1:0]     s_axis_tdata,
  input  logic [IN_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [3:0]              s_axis_tuser,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [WORD_WIDTH-1:0]   w_data,
  output logic [3:0]              w_type,
  output logic [3:0]              w_bytes,
  output logic                    w_last,
  output logic                    w_valid,
  input  logic                    w_ready,
  output logic                    err_tuser
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    HOLD  = 2'd2,
    PADW  = 2'd3
  } state_t;

`ifdef ASCON_PACKER_PAD_EN
  localparam logic [3:0] T_AD  = 4'd3;
  localparam logic [3:0] T_PT  = 4'd4;
  localparam logic [3:0] T_CT  = 4'd5;
  localparam logic [3:0] T_MSG = 4'd7;
  localparam logic [3:0] T_Z   = 4'd8;

  function automatic logic f_pad_type(input logic [3:0] t);
    case (t)
      T_AD, T_PT, T_CT, T_MSG, T_Z: f_pad_type = 1'b1;
      default:                      f_pad_type = 1'b0;
    endcase
  endfunction

  logic r_pad_pend, w_pad_pend_nxt;
`endif

  state_t                  r_state, w_state_nxt;
  logic [31:0]             r_lo, w_lo_nxt;
  logic [3:0]              r_lo_type, w_lo_type_nxt;
  logic [WORD_WIDTH-1:0]   r_data, w_data_nxt;
  logic [3:0]              r_type, w_type_nxt;
  logic [3:0]              r_bytes, w_bytes_nxt;
  logic                    r_last, w_last_nxt;
  logic                    r_err, w_err_nxt;
  logic                    r_run;

  logic                    w_tready;
  logic                    w_beat;
  logic [3:0]              w_keep;
  logic [31:0]             w_beat_data;
  logic [2:0]              w_pop;
  logic                    w_complete;
  logic [WORD_WIDTH-1:0]   w_word;
  logic [3:0]              w_wbytes;
  logic                    w_wlast;
  logic [3:0]              w_wtype;

  assign w_valid   = (r_state == HOLD) || (r_state == PADW);
  assign w_data    = r_data;
  assign w_type    = r_type;
  assign w_bytes   = r_bytes;
  assign w_last    = r_last;
  assign err_tuser = r_err;

  // r_run keeps tready low while in reset and for the first cycle after it.
  // With padding, a full last word must drain into PADW before new beats.
`ifdef ASCON_PACKER_PAD_EN
  assign w_tready = r_run && (r_state != PADW) && !r_pad_pend && (!w_valid || w_ready);
`else
  assign w_tready = r_run && (r_state != PADW) && (!w_valid || w_ready);
`endif
  assign s_axis_tready = w_tready;
  assign w_beat        = s_axis_tvalid && w_tready;

  // Non-last beats are always full, whatever tkeep says.
  assign w_keep = s_axis_tlast ? s_axis_tkeep : 4'hF;
  assign w_pop  = {2'b00, w_keep[0]} + {2'b00, w_keep[1]}
                + {2'b00, w_keep[2]} + {2'b00, w_keep[3]};

  always_comb begin
    w_beat_data = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (w_keep[i]) w_beat_data[8*i +: 8] = s_axis_tdata[8*i +: 8];
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_lo_nxt      = r_lo;
    w_lo_type_nxt = r_lo_type;
    w_data_nxt    = r_data;
    w_type_nxt    = r_type;
    w_bytes_nxt   = r_bytes;
    w_last_nxt    = r_last;
    w_err_nxt     = r_err;
`ifdef ASCON_PACKER_PAD_EN
    w_pad_pend_nxt = r_pad_pend;
`endif
    w_complete = 1'b0;
    w_word     = '0;
    w_wbytes   = '0;
    w_wlast    = 1'b0;
    w_wtype    = '0;

    // Word formation from the accepted beat.
    if (w_beat) begin
      if (r_state == HALF) begin
        w_complete = 1'b1;
        w_word     = {w_beat_data, r_lo};
        w_wbytes   = 4'd4 + {1'b0, w_pop};
        w_wlast    = s_axis_tlast;
        w_wtype    = r_lo_type;
        if (s_axis_tuser != r_lo_type) w_err_nxt = 1'b1;
      end else if (s_axis_tlast) begin
        w_complete = 1'b1;
        w_word     = {32'h0, w_beat_data};
        w_wbytes   = {1'b0, w_pop};
        w_wlast    = 1'b1;
        w_wtype    = s_axis_tuser;
      end else begin
        w_lo_nxt      = w_beat_data;
        w_lo_type_nxt = s_axis_tuser;
      end
    end

    if (w_complete) begin
      w_state_nxt = HOLD;
      w_data_nxt  = w_word;
      w_bytes_nxt = w_wbytes;
      w_last_nxt  = w_wlast;
      w_type_nxt  = w_wtype;
`ifdef ASCON_PACKER_PAD_EN
      w_pad_pend_nxt = 1'b0;
      if (w_wlast && f_pad_type(w_wtype)) begin
        if (w_wbytes == 4'd8) begin
          w_last_nxt     = 1'b0;
          w_pad_pend_nxt = 1'b1;
        end else begin
          w_data_nxt = w_word | (64'h1 << {w_wbytes[2:0], 3'b000});
        end
      end
`endif
    end else begin
      case (r_state)
        EMPTY: if (w_beat) w_state_nxt = HALF;
        HOLD: begin
          if (w_ready) begin
`ifdef ASCON_PACKER_PAD_EN
            if (r_pad_pend) begin
              w_state_nxt    = PADW;
              w_data_nxt     = 64'h1;
              w_bytes_nxt    = 4'd0;
              w_last_nxt     = 1'b1;
              w_pad_pend_nxt = 1'b0;
            end else begin
              w_state_nxt = w_beat ? HALF : EMPTY;
            end
`else
            w_state_nxt = w_beat ? HALF : EMPTY;
`endif
          end
        end
        PADW: if (w_ready) w_state_nxt = EMPTY;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= EMPTY;
      r_lo      <= '0;
      r_lo_type <= '0;
      r_data    <= '0;
      r_type    <= '0;
      r_bytes   <= '0;
      r_last    <= 1'b0;
      r_err     <= 1'b0;
      r_run     <= 1'b0;
`ifdef ASCON_PACKER_PAD_EN
      r_pad_pend <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_lo      <= w_lo_nxt;
      r_lo_type <= w_lo_type_nxt;
      r_data    <= w_data_nxt;
      r_type    <= w_type_nxt;
      r_bytes   <= w_bytes_nxt;
      r_last    <= w_last_nxt;
      r_err     <= w_err_nxt;
      r_run     <= 1'b1;
`ifdef ASCON_PACKER_PAD_EN
      r_pad_pend <= w_pad_pend_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ascon_axis_word_packer.sv
// Directed bench for ascon_axis_word_packer; expectations follow the build
// (ASCON_PACKER_PAD_EN defined or not).
module tb_ascon_axis_word_packer;

  localparam logic [3:0] T_KEY = 4'd1, T_NONCE = 4'd2, T_AD = 4'd3,
                         T_PT = 4'd4, T_MSG = 4'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic [3:0]  s_axis_tuser;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] w_data;
  logic [3:0]  w_type;
  logic [3:0]  w_bytes;
  logic        w_last;
  logic        w_valid;
  logic        w_ready;
  logic        err_tuser;

  int n_chk = 0;
  int n_bad = 0;

  logic [63:0] q_data  [0:31];
  logic [3:0]  q_bytes [0:31];
  logic        q_last  [0:31];
  logic [3:0]  q_type  [0:31];
  int          q_n = 0;
  int          base;

  always #5 clk = ~clk;

  ascon_axis_word_packer #(.IN_WIDTH(32), .WORD_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .w_data(w_data), .w_type(w_type), .w_bytes(w_bytes), .w_last(w_last),
    .w_valid(w_valid), .w_ready(w_ready), .err_tuser(err_tuser)
  );

  // Word monitor: handshake values are stable between negedge+1 and posedge.
  always @(negedge clk) begin
    #1;
    if (!rst && w_valid && w_ready && q_n < 32) begin
      q_data[q_n]  <= w_data;
      q_bytes[q_n] <= w_bytes;
      q_last[q_n]  <= w_last;
      q_type[q_n]  <= w_type;
      q_n          <= q_n + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_word(input int idx, input string tag, input logic [63:0] d,
                            input logic [3:0] b, input logic l, input logic [3:0] t);
    check({tag, "_data"},  q_data[idx],  d);
    check({tag, "_bytes"}, {60'h0, q_bytes[idx]}, {60'h0, b});
    check({tag, "_last"},  {63'h0, q_last[idx]},  {63'h0, l});
    check({tag, "_type"},  {60'h0, q_type[idx]},  {60'h0, t});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at posedge+1 of the accepting edge.
  task automatic send(input logic [31:0] d, input logic [3:0] k,
                      input logic [3:0] u, input logic l);
    bit ok;
    @(negedge clk);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      #1;
      if (s_axis_tready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) check("send_timeout", 64'd0, 64'd1);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, {63'h0, w_valid}, 64'h0);
    check({tag, "_data"},  w_data, 64'h0);
    check({tag, "_bytes"}, {60'h0, w_bytes}, 64'h0);
    check({tag, "_last"},  {63'h0, w_last}, 64'h0);
    check({tag, "_type"},  {60'h0, w_type}, 64'h0);
    check({tag, "_err"},   {63'h0, err_tuser}, 64'h0);
    check({tag, "_tready"}, {63'h0, s_axis_tready}, 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; w_ready = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
    s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("rst0");
    rst = 1'b0;
    w_ready = 1'b1;

    // Two full PT beats, single word.
    base = q_n;
    send(32'h03020100, 4'hF, T_PT, 1'b0);
    check("half_no_valid", {63'h0, w_valid}, 64'h0);
    send(32'h07060504, 4'hF, T_PT, 1'b1);
    check("latency_valid", {63'h0, w_valid}, 64'h1);
    idle(4);
`ifdef ASCON_PACKER_PAD_EN
    check("pt_count", q_n - base, 2);
    check_word(base,     "pt_w0", 64'h0706050403020100, 4'd8, 1'b0, T_PT);
    check_word(base + 1, "pt_pad", 64'h1, 4'd0, 1'b1, T_PT);
`else
    check("pt_count", q_n - base, 1);
    check_word(base, "pt_w0", 64'h0706050403020100, 4'd8, 1'b1, T_PT);
`endif

    // Three MSG beats, partial last beat with junk in masked bytes.
    base = q_n;
    send(32'h13121110, 4'hF, T_MSG, 1'b0);
    send(32'h17161514, 4'hF, T_MSG, 1'b0);
    send(32'hDDCCBBAA, 4'b0011, T_MSG, 1'b1);
    idle(4);
    check("msg_count", q_n - base, 2);
    check_word(base, "msg_w0", 64'h1716151413121110, 4'd8, 1'b0, T_MSG);
`ifdef ASCON_PACKER_PAD_EN
    check_word(base + 1, "msg_w1", 64'h0000_0000_0001_BBAA, 4'd2, 1'b1, T_MSG);
`else
    check_word(base + 1, "msg_w1", 64'h0000_0000_0000_BBAA, 4'd2, 1'b1, T_MSG);
`endif

    // KEY packet with the core stalled after the first word.
    base = q_n;
    w_ready = 1'b0;
    send(32'hA3A2A1A0, 4'hF, T_KEY, 1'b0);
    send(32'hA7A6A5A4, 4'hF, T_KEY, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("stall_tready", {63'h0, s_axis_tready}, 64'h0);
      check("stall_valid",  {63'h0, w_valid}, 64'h1);
      check("stall_data",   w_data, 64'hA7A6A5A4A3A2A1A0);
    end
    @(negedge clk);
    w_ready = 1'b1;
    send(32'hABAAA9A8, 4'hF, T_KEY, 1'b0);
    send(32'hAFAEADAC, 4'hF, T_KEY, 1'b1);
    idle(4);
    check("key_count", q_n - base, 2);
    check_word(base,     "key_w0", 64'hA7A6A5A4A3A2A1A0, 4'd8, 1'b0, T_KEY);
    check_word(base + 1, "key_w1", 64'hAFAEADACABAAA9A8, 4'd8, 1'b1, T_KEY);

    // Empty AD packet.
    base = q_n;
    send(32'h12345678, 4'h0, T_AD, 1'b1);
    idle(3);
    check("empty_count", q_n - base, 1);
`ifdef ASCON_PACKER_PAD_EN
    check_word(base, "empty", 64'h1, 4'd0, 1'b1, T_AD);
`else
    check_word(base, "empty", 64'h0, 4'd0, 1'b1, T_AD);
`endif
    check("err_before", {63'h0, err_tuser}, 64'h0);

    // TUSER switch inside a word.
    base = q_n;
    send(32'h33323130, 4'hF, T_AD, 1'b0);
    send(32'h37363534, 4'hF, T_PT, 1'b1);
    idle(5);
    check("err_set", {63'h0, err_tuser}, 64'h1);
`ifdef ASCON_PACKER_PAD_EN
    check("sw_count", q_n - base, 2);
    check_word(base, "sw_w0", 64'h3736353433323130, 4'd8, 1'b0, T_AD);
    check_word(base + 1, "sw_pad", 64'h1, 4'd0, 1'b1, T_AD);
`else
    check("sw_count", q_n - base, 1);
    check_word(base, "sw_w0", 64'h3736353433323130, 4'd8, 1'b1, T_AD);
`endif
    idle(3);
    check("err_sticky", {63'h0, err_tuser}, 64'h1);

    // Reset with a partial word held, then a fresh NONCE packet.
    send(32'hEEEEEEEE, 4'hF, T_NONCE, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_outputs_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    base = q_n;
    send(32'h53525150, 4'hF, T_NONCE, 1'b0);
    send(32'h57565554, 4'hF, T_NONCE, 1'b1);
    idle(4);
    check("nonce_count", q_n - base, 1);
    check_word(base, "nonce_w0", 64'h5756555453525150, 4'd8, 1'b1, T_NONCE);
    check("err_cleared", {63'h0, err_tuser}, 64'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
